// File: rtl/net_pkt_len_enforcer.sv
// Egress packet-length enforcer: forwards AXI-Stream beats through a one-deep
// register slice, truncating packets longer than MAX_BEATS and dropping the tail.
module net_pkt_len_enforcer #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int AXIS_DEST_WIDTH   = 4,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int TRUNC_COUNT_WIDTH = 16,
  localparam int ID_W   = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH,
  localparam int DEST_W = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH,
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]    axis_egr_in_tdata,
  input  logic [ID_W-1:0]              axis_egr_in_tid,
  input  logic [DEST_W-1:0]            axis_egr_in_tdest,
  input  logic [KEEP_W-1:0]            axis_egr_in_tkeep,
  input  logic                         axis_egr_in_tlast,
  input  logic                         axis_egr_in_tvalid,
  output logic                         axis_egr_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]    axis_egr_out_tdata,
  output logic [ID_W-1:0]              axis_egr_out_tid,
  output logic [DEST_W-1:0]            axis_egr_out_tdest,
  output logic [KEEP_W-1:0]            axis_egr_out_tkeep,
  output logic                         axis_egr_out_tlast,
  output logic                         axis_egr_out_tvalid,
  input  logic                         axis_egr_out_tready,
  input  logic                         decouple,
  output logic                         decouple_done,
  output logic [TRUNC_COUNT_WIDTH-1:0] trunc_count,
  output logic                         trunc_sticky,
  input  logic                         clear_stats
);

  localparam int MAX_BEATS = (MAX_PACKET_LENGTH + KEEP_W - 1) / KEEP_W;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_DROP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             load;
  logic             at_limit;
  logic             trunc_evt;

  always_comb begin
    axis_egr_in_tready = 1'b0;
    if (!aresetn) begin
      axis_egr_in_tready = 1'b0;
    end else if (state == S_DROP) begin
      axis_egr_in_tready = 1'b1;
    end else if (state == S_IDLE && decouple) begin
      axis_egr_in_tready = 1'b0;
    end else begin
      axis_egr_in_tready = !axis_egr_out_tvalid || axis_egr_out_tready;
    end
  end

  // Truncation is decided from the registered count, keeping out_tready off the data path.
  assign accept    = axis_egr_in_tvalid && axis_egr_in_tready;
  assign load      = accept && (state != S_DROP);
  assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign trunc_evt = load && !axis_egr_in_tlast && at_limit;

  assign decouple_done = decouple && (state == S_IDLE) && !axis_egr_out_tvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state               <= S_IDLE;
      beat_cnt            <= '0;
      axis_egr_out_tvalid <= 1'b0;
      axis_egr_out_tdata  <= '0;
      axis_egr_out_tid    <= '0;
      axis_egr_out_tdest  <= '0;
      axis_egr_out_tkeep  <= '0;
      axis_egr_out_tlast  <= 1'b0;
      trunc_count         <= '0;
      trunc_sticky        <= 1'b0;
    end else begin
      if (load) begin
        axis_egr_out_tvalid <= 1'b1;
        axis_egr_out_tdata  <= axis_egr_in_tdata;
        axis_egr_out_tid    <= axis_egr_in_tid;
        axis_egr_out_tdest  <= axis_egr_in_tdest;
        axis_egr_out_tkeep  <= axis_egr_in_tkeep;
        axis_egr_out_tlast  <= axis_egr_in_tlast || at_limit;
      end else if (axis_egr_out_tready && axis_egr_out_tvalid) begin
        axis_egr_out_tvalid <= 1'b0;
      end

      if (accept) begin
        case (state)
          S_DROP: begin
            if (axis_egr_in_tlast) begin
              state <= S_IDLE;
            end
          end
          default: begin
            if (axis_egr_in_tlast) begin
              state    <= S_IDLE;
              beat_cnt <= '0;
            end else if (at_limit) begin
              state    <= S_DROP;
              beat_cnt <= '0;
            end else begin
              state    <= S_PASS;
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        endcase
      end

      if (clear_stats) begin
        trunc_count  <= '0;
        trunc_sticky <= 1'b0;
      end else if (trunc_evt) begin
        if (trunc_count != '1) begin
          trunc_count <= trunc_count + TRUNC_COUNT_WIDTH'(1);
        end
        trunc_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_net_pkt_len_enforcer.sv
// Directed self-checking bench for net_pkt_len_enforcer with MAX_BEATS = 8
// and a 4-bit truncation counter so saturation is reachable quickly.
module tb_net_pkt_len_enforcer;

  typedef logic [80:0] ent_t;

  logic        clk;
  logic        aresetn;
  logic [63:0] in_tdata;
  logic [3:0]  in_tid;
  logic [3:0]  in_tdest;
  logic [7:0]  in_tkeep;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] out_tdata;
  logic [3:0]  out_tid;
  logic [3:0]  out_tdest;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic        decouple;
  logic        decouple_done;
  logic [3:0]  trunc_count;
  logic        trunc_sticky;
  logic        clear_stats;

  logic        ready_main;
  logic        rnd_ready;
  logic        bp_en;

  int          checks;
  int          errors;
  ent_t        q[$];
  logic        hold_pending;
  ent_t        held;

  assign out_tready = bp_en ? rnd_ready : ready_main;

  net_pkt_len_enforcer #(
    .AXIS_BUS_WIDTH   (64),
    .AXIS_ID_WIDTH    (4),
    .AXIS_DEST_WIDTH  (4),
    .MAX_PACKET_LENGTH(64),
    .TRUNC_COUNT_WIDTH(4)
  ) dut (
    .aclk               (clk),
    .aresetn            (aresetn),
    .axis_egr_in_tdata  (in_tdata),
    .axis_egr_in_tid    (in_tid),
    .axis_egr_in_tdest  (in_tdest),
    .axis_egr_in_tkeep  (in_tkeep),
    .axis_egr_in_tlast  (in_tlast),
    .axis_egr_in_tvalid (in_tvalid),
    .axis_egr_in_tready (in_tready),
    .axis_egr_out_tdata (out_tdata),
    .axis_egr_out_tid   (out_tid),
    .axis_egr_out_tdest (out_tdest),
    .axis_egr_out_tkeep (out_tkeep),
    .axis_egr_out_tlast (out_tlast),
    .axis_egr_out_tvalid(out_tvalid),
    .axis_egr_out_tready(out_tready),
    .decouple           (decouple),
    .decouple_done      (decouple_done),
    .trunc_count        (trunc_count),
    .trunc_sticky       (trunc_sticky),
    .clear_stats        (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rnd_ready = 1'b1;
  always @(posedge clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input ent_t got, input ent_t exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output capture plus stall-stability check, sampled on the falling edge.
  always @(negedge clk) begin
    if (hold_pending && aresetn) begin
      chk("hold_stable", {out_tvalid, out_tlast, out_tid, out_tdest, out_tkeep, out_tdata},
          {1'b1, held});
    end
    if (aresetn && out_tvalid && out_tready) begin
      q.push_back({out_tlast, out_tid, out_tdest, out_tkeep, out_tdata});
    end
    hold_pending = aresetn && out_tvalid && !out_tready;
    held         = {out_tlast, out_tid, out_tdest, out_tkeep, out_tdata};
  end

  function automatic ent_t mk(input int pkt, input int i, input bit last);
    return {last, 4'(pkt), ~4'(pkt), 8'hFF, 32'(pkt), 32'(i)};
  endfunction

  task automatic drive(input int pkt, input int i, input int total);
    in_tvalid = 1'b1;
    in_tdata  = {32'(pkt), 32'(i)};
    in_tid    = 4'(pkt);
    in_tdest  = ~4'(pkt);
    in_tkeep  = 8'hFF;
    in_tlast  = (i == total - 1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input int pkt, input int first, input int last_i, input int total);
    for (int i = first; i <= last_i; i++) begin
      int n;
      drive(pkt, i, total);
      n = 0;
      @(negedge clk);
      while (!in_tready && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("accept_timeout", ent_t'(n < 200), ent_t'(1));
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input int pkt, input int n);
    chk("pkt_len", ent_t'(q.size()), ent_t'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk("pkt_beat", q[i], mk(pkt, i, i == n - 1));
    end
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    aresetn     = 1'b0;
    in_tdata    = '0;
    in_tid      = '0;
    in_tdest    = '0;
    in_tkeep    = '0;
    in_tlast    = 1'b0;
    in_tvalid   = 1'b0;
    decouple    = 1'b0;
    clear_stats = 1'b0;
    ready_main  = 1'b1;
    bp_en       = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_tvalid", ent_t'(out_tvalid), ent_t'(0));
    chk("rst_out_payload", {out_tlast, out_tid, out_tdest, out_tkeep, out_tdata}, '0);
    chk("rst_in_tready", ent_t'(in_tready), ent_t'(0));
    chk("rst_trunc_count", ent_t'(trunc_count), ent_t'(0));
    chk("rst_trunc_sticky", ent_t'(trunc_sticky), ent_t'(0));
    chk("rst_decouple_done", ent_t'(decouple_done), ent_t'(0));
    #2 aresetn = 1'b1;
    @(posedge clk);
    #1;

    // 5-beat packet, one-cycle latency
    send(1, 0, 0, 5);
    chk("lat_tvalid", ent_t'(out_tvalid), ent_t'(1));
    chk("lat_tdata", ent_t'(out_tdata), ent_t'({32'd1, 32'd0}));
    send(1, 1, 4, 5);
    idle(3);
    check_pkt(1, 5);
    chk("p1_trunc_count", ent_t'(trunc_count), ent_t'(0));

    // Exactly MAX_BEATS beats: not truncated, returns to IDLE
    send(2, 0, 7, 8);
    idle(3);
    check_pkt(2, 8);
    chk("p2_trunc_count", ent_t'(trunc_count), ent_t'(0));
    chk("p2_trunc_sticky", ent_t'(trunc_sticky), ent_t'(0));
    decouple = 1'b1;
    #1;
    chk("p2_idle_done", ent_t'(decouple_done), ent_t'(1));
    decouple = 1'b0;
    idle(1);

    // 12-beat packet: truncated at beat 8, tail sunk
    send(3, 0, 7, 12);
    chk("p3_forced_tlast", ent_t'(out_tlast), ent_t'(1));
    chk("p3_trunc_count", ent_t'(trunc_count), ent_t'(1));
    chk("p3_trunc_sticky", ent_t'(trunc_sticky), ent_t'(1));
    ready_main = 1'b0;
    for (int i = 8; i < 12; i++) begin
      drive(3, i, 12);
      @(negedge clk);
      chk("p3_drop_tready", ent_t'(in_tready), ent_t'(1));
      @(posedge clk);
      #1;
    end
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    ready_main = 1'b1;
    idle(3);
    check_pkt(3, 8);
    send(4, 0, 2, 3);
    idle(3);
    check_pkt(4, 3);
    chk("p4_trunc_count", ent_t'(trunc_count), ent_t'(1));

    // Random backpressure
    bp_en = 1'b1;
    send(10, 0, 5, 6);
    bp_en = 1'b0;
    idle(4);
    check_pkt(10, 6);

    // Decouple raised mid-packet
    send(5, 0, 2, 6);
    decouple = 1'b1;
    send(5, 3, 5, 6);
    drive(6, 0, 4);
    repeat (3) begin
      @(negedge clk);
      chk("dec_blocked", ent_t'(in_tready), ent_t'(0));
    end
    chk("dec_done", ent_t'(decouple_done), ent_t'(1));
    check_pkt(5, 6);
    @(posedge clk);
    #1;
    decouple = 1'b0;
    #1;
    chk("dec_done_release", ent_t'(decouple_done), ent_t'(0));
    send(6, 0, 3, 4);
    idle(3);
    check_pkt(6, 4);

    // Reset mid-packet with a beat held in the slice
    send(7, 0, 2, 6);
    ready_main = 1'b0;
    drive(7, 3, 6);
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", ent_t'(out_tvalid), ent_t'(0));
    chk("mid_rst_tdata", ent_t'(out_tdata), ent_t'(0));
    chk("mid_rst_in_tready", ent_t'(in_tready), ent_t'(0));
    chk("mid_rst_count", ent_t'(trunc_count), ent_t'(0));
    @(negedge clk);
    @(negedge clk);
    in_tvalid  = 1'b0;
    ready_main = 1'b1;
    #2 aresetn = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    send(8, 0, 7, 8);
    idle(3);
    check_pkt(8, 8);
    chk("post_rst_count", ent_t'(trunc_count), ent_t'(0));

    // Counter saturation
    for (int p = 0; p < 15; p++) begin
      send(20 + p, 0, 8, 9);
    end
    idle(3);
    q.delete();
    chk("sat_count", ent_t'(trunc_count), ent_t'(4'hF));
    chk("sat_sticky", ent_t'(trunc_sticky), ent_t'(1));
    send(35, 0, 8, 9);
    idle(3);
    check_pkt(35, 8);
    chk("sat_hold", ent_t'(trunc_count), ent_t'(4'hF));

    // clear_stats coincident with a truncating beat
    send(40, 0, 6, 9);
    clear_stats = 1'b1;
    send(40, 7, 7, 9);
    clear_stats = 1'b0;
    chk("clr_count", ent_t'(trunc_count), ent_t'(0));
    chk("clr_sticky", ent_t'(trunc_sticky), ent_t'(0));
    send(40, 8, 8, 9);
    idle(3);
    check_pkt(40, 8);
    chk("clr_count_final", ent_t'(trunc_count), ent_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_pkt_len_enforcer.md
# net_pkt_len_enforcer

Egress-side protocol enforcer that sits directly upstream of the network bandwidth throttler, between the application's egress AXI-Stream and the throttler input. It guarantees that no packet delivered downstream exceeds MAX_BEATS beats. Oversized packets are truncated by forcing TLAST on beat MAX_BEATS, and the remainder is silently dropped. This bounds the per-packet token charge the throttler applies. A one-deep full-throughput register slice isolates timing, and a packet-boundary decouple request lets management quiesce the application cleanly.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64: data width in bits (multiple of 8).
- AXIS_ID_WIDTH, 4: TID width; ports are sized max(1, value).
- AXIS_DEST_WIDTH, 4: TDEST width; ports are sized max(1, value).
- MAX_PACKET_LENGTH, 1522: maximum packet size in bytes.
- MAX_BEATS (localparam): ceil(MAX_PACKET_LENGTH / (AXIS_BUS_WIDTH/8)); 191 at defaults.
- TRUNC_COUNT_WIDTH, 16: width of the truncation counter.

Ports:
- aclk, input, 1: sole clock. Everything is synchronous to it.
- aresetn, input, 1: asynchronous, active-low reset.
- axis_egr_in_tdata/tid/tdest/tkeep/tlast/tvalid, input, widths as parameterised: application egress stream.
- axis_egr_in_tready, output, 1: ready for the input stream.
- axis_egr_out_tdata/tid/tdest/tkeep/tlast/tvalid, output: registered stream to the throttler.
- axis_egr_out_tready, input, 1: ready from the throttler.
- decouple, input, 1: request to block new packets.
- decouple_done, output, 1: high when idle at a packet boundary while decouple is held.
- trunc_count, output, TRUNC_COUNT_WIDTH: saturating count of truncated packets.
- trunc_sticky, output, 1: set on the first truncation.
- clear_stats, input, 1: synchronous clear of trunc_count and trunc_sticky.

## Operation
- States:
  - IDLE: between packets.
  - PASS: inside a packet, forwarding beats.
  - DROP: discarding the tail of an oversized packet.
- beat_cnt, width clog2(MAX_BEATS+1), counts accepted input beats of the current packet.
- Accepted input beat: tvalid && tready.
- Output slice: out_valid register.
  - Loads on an accepted beat unless DROP.
  - Clears when out_tready && out_valid and no load occurs in that cycle.
- axis_egr_in_tready:
  - IDLE with decouple=1: 0.
  - DROP: 1 (sink).
  - Otherwise: (!out_valid || axis_egr_out_tready).
- IDLE/PASS accepted beat:
  - Forward tdata/tid/tdest/tkeep unchanged.
  - If tlast: go to IDLE, beat_cnt ← 0.
  - Else if beat_cnt == MAX_BEATS-1: forward with tlast forced to 1, go to DROP, beat_cnt ← 0, increment trunc_count (saturating at all-ones), set trunc_sticky.
  - Else: go to PASS, beat_cnt ← beat_cnt+1.
- DROP:
  - Every input beat is accepted and discarded.
  - An input tlast returns the block to IDLE.
  - decouple does not stall the drop.
- decouple:
  - Honoured only in IDLE.
  - A packet in flight (PASS or DROP) always completes first.
  - decouple_done = decouple && state==IDLE && !out_valid.
- clear_stats has priority over a same-cycle increment; the result is count 0, sticky 0.
- A packet of exactly MAX_BEATS beats with tlast on the final beat is not truncated.

## Timing
- Reset values: out_tvalid 0, out tlast/tdata/tkeep/tid/tdest 0, in_tready 0 while aresetn low, state IDLE, beat_cnt 0, trunc_count 0, trunc_sticky 0, decouple_done 0.
- Reset asserted mid-packet:
  - All state and the slice are cleared immediately.
  - Any in-flight beat is lost.
  - The first beat after release is treated as the start of a new packet.
- Latency: input accept to out_tvalid is 1 cycle.
- Throughput: 1 beat/cycle with out_tready held high.
- out_tvalid and payload are stable until accepted (AXIS compliant). out_tvalid never deasserts without a handshake.
- The decision to force tlast is made in the accept cycle from the registered beat_cnt. No combinational path exists from axis_egr_out_tready to out_tdata.
- Combinational paths: axis_egr_out_tready → axis_egr_in_tready, and decouple → axis_egr_in_tready.
- trunc_count/trunc_sticky update the cycle after the truncating beat is accepted.

## Test plan
Unless noted, tests use MAX_PACKET_LENGTH=64, AXIS_BUS_WIDTH=64, so MAX_BEATS=8.
- 5-beat packet, out_tready=1 -> 5 output beats 1 cycle delayed, tlast on beat 5 only, trunc_count 0.
- 8-beat packet (tlast on beat 8) -> 8 beats out unchanged, no truncation, state IDLE afterward.
- 12-beat packet -> 8 beats out with tlast forced on beat 8; beats 9–12 accepted with in_tready=1 and not output; trunc_count=1, trunc_sticky=1; the next packet passes intact.
- Random out_tready backpressure on a 6-beat packet -> data order preserved, no beat lost or duplicated, out payload stable while out_tvalid && !out_tready.
- decouple raised at beat 3 of a 6-beat packet -> beats 4–6 still pass; the next packet is blocked (in_tready=0); decouple_done=1 after the slice drains; release -> the blocked packet flows.
- aresetn pulsed low during beat 4; trunc_count saturated at 0xFFFF before a further truncation; clear_stats coincident with a truncation -> out_tvalid drops to 0 immediately; count holds 0xFFFF; count and sticky read 0.
